// File: rtl/alpha_adapt_pkg.sv
// Shared Q2.23 constants, FSM encoding and saturation helper for the adaptive notch blocks.
package alpha_adapt_pkg;

  localparam int unsigned CoefSize = 25;
  localparam int unsigned Frac     = CoefSize - 2;
  localparam int unsigned WideSize = CoefSize + 2;

  localparam logic signed [CoefSize-1:0] QMax = 25'sh0FFFFFF;
  localparam logic signed [CoefSize-1:0] QMin = 25'sh1000000;

  // Same bounds sign-extended to the 27-bit accumulation width.
  localparam logic signed [WideSize-1:0] WideMax = 27'sh0FFFFFF;
  localparam logic signed [WideSize-1:0] WideMin = 27'sh7000000;

  typedef enum logic [2:0] {
    StIdle,
    StCapt,
    StM1,
    StM2,
    StM3,
    StUpd
  } state_e;

  function automatic logic signed [CoefSize-1:0] sat25(input logic signed [WideSize-1:0] v);
    logic signed [CoefSize-1:0] r;
    if (v > WideMax) begin
      r = QMax;
    end else if (v < WideMin) begin
      r = QMin;
    end else begin
      r = v[CoefSize-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/alpha_adapt_mult_s25.sv
// 25x25 signed multiplier with a single output register (one-cycle latency).
module mult_s25 (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic signed [24:0] a_i,
  input  logic signed [24:0] b_i,
  output logic signed [49:0] p_o
);

  logic signed [49:0] prod_q;
  logic signed [49:0] prod_d;

  always_comb begin
    prod_d = a_i * b_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign p_o = prod_q;

endmodule

// File: rtl/alpha_adapt.sv
// Gradient update of the notch coefficient alpha; two shared multipliers driven by a 6-state FSM.
module alpha_adapt
  import alpha_adapt_pkg::*;
#(
  parameter int unsigned                 COEF_SIZE = CoefSize,
  parameter int unsigned                 DATA_SIZE = CoefSize,
  parameter int unsigned                 FRAC      = Frac,
  parameter logic signed [COEF_SIZE-1:0] R         = 25'sd0,
  parameter logic signed [COEF_SIZE-1:0] U         = 25'sd0,
  parameter logic signed [COEF_SIZE-1:0] A_INIT    = 25'sd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] y_in,
  input  logic [DATA_SIZE-2:0] x_in,
  input  logic                 adapt_en,
  output logic [COEF_SIZE-1:0] alpha_out,
  output logic                 alpha_valid,
  output logic                 overrun
);

  localparam int unsigned Wide = COEF_SIZE + 2;
  localparam int unsigned Prod = 2 * COEF_SIZE;

  state_e state_q, state_d;

  logic signed [DATA_SIZE-1:0] y_cur_q, x_cur_q, y_prev_q, x_prev_q;
  logic signed [COEF_SIZE-1:0] alpha_q;
  logic signed [Wide-1:0]      sum_q;
  logic                        valid_q;
  logic                        overrun_q;

  logic signed [COEF_SIZE-1:0] mul_a_x, mul_a_y, mul_b_x, mul_b_y;
  logic signed [Prod-1:0]      prod_a, prod_b;

  logic signed [COEF_SIZE-1:0] z5, z4, diff;
  logic signed [COEF_SIZE:0]   diff_w;
  logic signed [Wide-1:0]      delta, sum_d;
  logic                        unused_prod;

  // Products are Q4.46; >>>FRAC brings them back to Q2.23 (z4/z5 truncated to 25 bits).
  assign z5     = prod_a[FRAC +: COEF_SIZE];
  assign z4     = prod_b[FRAC +: COEF_SIZE];
  assign diff_w = {x_prev_q[DATA_SIZE-1], x_prev_q} - {z4[COEF_SIZE-1], z4};
  assign diff   = sat25({diff_w[COEF_SIZE], diff_w});
  assign delta  = prod_a[FRAC +: Wide];
  assign sum_d  = {{2{alpha_q[COEF_SIZE-1]}}, alpha_q} + delta;

  assign unused_prod = ^{prod_a[FRAC-1:0], prod_b[FRAC-1:0], prod_b[Prod-1:FRAC+COEF_SIZE]};

  always_comb begin
    state_d = state_q;
    mul_a_x = '0;
    mul_a_y = '0;
    mul_b_x = '0;
    mul_b_y = '0;
    unique case (state_q)
      StIdle: begin
        if (filter_done) begin
          state_d = StCapt;
        end
      end
      StCapt: state_d = StM1;
      StM1: begin
        mul_a_x = U;
        mul_a_y = y_cur_q;
        mul_b_x = R;
        mul_b_y = y_prev_q;
        state_d = StM2;
      end
      StM2: begin
        mul_a_x = z5;
        mul_a_y = diff;
        state_d = StM3;
      end
      StM3:    state_d = StUpd;
      StUpd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == StUpd);
      if (filter_done && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_cur_q  <= '0;
      x_cur_q  <= '0;
      y_prev_q <= '0;
      x_prev_q <= '0;
      sum_q    <= '0;
      alpha_q  <= A_INIT;
    end else begin
      if (state_q == StCapt) begin
        y_cur_q <= y_in;
        x_cur_q <= {x_in[DATA_SIZE-2], x_in};
      end
      if (state_q == StM3) begin
        sum_q <= sum_d;
      end
      // History shifts only after the update has consumed the old values.
      if (state_q == StUpd) begin
        if (adapt_en) begin
          alpha_q <= sat25(sum_q);
        end
        y_prev_q <= y_cur_q;
        x_prev_q <= x_cur_q;
      end
    end
  end

  mult_s25 u_mult_a (
    .clk_i (clk),
    .rst_i (reset),
    .a_i   (mul_a_x),
    .b_i   (mul_a_y),
    .p_o   (prod_a)
  );

  mult_s25 u_mult_b (
    .clk_i (clk),
    .rst_i (reset),
    .a_i   (mul_b_x),
    .b_i   (mul_b_y),
    .p_o   (prod_b)
  );

  assign alpha_out   = alpha_q;
  assign alpha_valid = valid_q;
  assign overrun     = overrun_q;

endmodule
